// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - round-robin arbiter sharing one 8x8 sequential multiplier
//
// Purpose:
//   Grants one of NREQ requesters at a time and latches that requester's
//   operands. It issues a single start strobe to the multiplier and follows the
//   multiplier's busy handshake. It then returns the 16-bit product with a
//   one-cycle done pulse to the granted requester.
//   Flow: IDLE -> ISSUE -> WAIT_BUSY -> WAIT_DONE -> DELIVER -> IDLE.
//
// Optional feature macro: MULT_ARB_TIMEOUT_EN
//   When defined, a watchdog counts cycles spent in WAIT_BUSY / WAIT_DONE.
//   When the count reaches TO_CYC, the operation is delivered with err_o=1 and
//   y_bo=0. When undefined, err_o is tied 0 and the arbiter waits indefinitely.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-high reset (shared with the multiplier)
//   req_i          per-requester request, held until the matching done_o bit
//   a_bi, b_bi     packed operands, requester k on bits [8k+7:8k]
//   grant_o        one-hot, requester currently being served
//   done_o         one-hot one-cycle pulse, y_bo valid for that requester
//   y_bo           product of the last completed operation
//   err_o          watchdog error, valid with done_o
//   busy_o         high whenever the sequencer is not idle
//   mult_a_bo/_b_bo operands driven to the multiplier
//   mult_start_o   start strobe to the multiplier
//   mult_busy_i    busy from the multiplier
//   mult_y_bi      product from the multiplier

module mult_arbiter #(
    parameter int NREQ   = 4,
    parameter int TO_CYC = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NREQ-1:0]   req_i,
    input  logic [8*NREQ-1:0] a_bi,
    input  logic [8*NREQ-1:0] b_bi,
    output logic [NREQ-1:0]   grant_o,
    output logic [NREQ-1:0]   done_o,
    output logic [15:0]       y_bo,
    output logic              err_o,
    output logic              busy_o,
    output logic [7:0]        mult_a_bo,
    output logic [7:0]        mult_b_bo,
    output logic              mult_start_o,
    input  logic              mult_busy_i,
    input  logic [15:0]       mult_y_bi
);

    localparam int IDXW = $clog2(NREQ);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        DELIVER   = 3'd4
    } state_t;

    state_t            state;
    logic [IDXW-1:0]   rr_ptr;

    logic [2*NREQ-1:0] req_dbl;
    logic [NREQ-1:0]   req_rot;
    logic              sel_valid;
    logic [IDXW-1:0]   sel_idx;
    logic [NREQ-1:0]   sel_oh;
    logic [7:0]        sel_a;
    logic [7:0]        sel_b;

    // Rotate the request vector so that bit 0 is the requester just after
    // rr_ptr; the lowest set bit of the rotated vector is then the winner.
    assign req_dbl = {req_i, req_i};
    assign req_rot = NREQ'(req_dbl >> (int'(rr_ptr) + 1));

    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                sel_valid = 1'b1;
                sel_idx   = IDXW'((int'(rr_ptr) + 1 + i) % NREQ);
            end
        end
    end

    always_comb begin
        sel_oh = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (sel_idx == IDXW'(i)) begin
                sel_oh[i] = 1'b1;
                sel_a     = a_bi[i*8 +: 8];
                sel_b     = b_bi[i*8 +: 8];
            end
        end
    end

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int CNTW = $clog2(TO_CYC + 1);
    logic [CNTW-1:0] to_cnt;
    logic            to_hit;

    assign to_hit = (to_cnt == CNTW'(TO_CYC - 1));
`else
    assign err_o = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            rr_ptr       <= IDXW'(NREQ - 1);
            grant_o      <= '0;
            done_o       <= '0;
            y_bo         <= '0;
            busy_o       <= 1'b0;
            mult_a_bo    <= '0;
            mult_b_bo    <= '0;
            mult_start_o <= 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
            err_o        <= 1'b0;
            to_cnt       <= '0;
`endif
        end else begin
            // Strobes default low so each is high for exactly one cycle.
            mult_start_o <= 1'b0;
            done_o       <= '0;
            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        grant_o      <= sel_oh;
                        mult_a_bo    <= sel_a;
                        mult_b_bo    <= sel_b;
                        rr_ptr       <= sel_idx;
                        mult_start_o <= 1'b1;
                        busy_o       <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT_BUSY;
`ifdef MULT_ARB_TIMEOUT_EN
                    to_cnt <= '0;
`endif
                end
                WAIT_BUSY: begin
                    if (mult_busy_i) begin
                        state <= WAIT_DONE;
`ifdef MULT_ARB_TIMEOUT_EN
                        to_cnt <= '0;
                    end else if (to_hit) begin
                        y_bo   <= '0;
                        err_o  <= 1'b1;
                        done_o <= grant_o;
                        state  <= DELIVER;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
`endif
                    end
                end
                WAIT_DONE: begin
                    // The first low sample of busy means the product is ready.
                    if (!mult_busy_i) begin
                        y_bo   <= mult_y_bi;
                        done_o <= grant_o;
                        state  <= DELIVER;
`ifdef MULT_ARB_TIMEOUT_EN
                        err_o  <= 1'b0;
                    end else if (to_hit) begin
                        y_bo   <= '0;
                        err_o  <= 1'b1;
                        done_o <= grant_o;
                        state  <= DELIVER;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
`endif
                    end
                end
                DELIVER: begin
                    grant_o <= '0;
                    busy_o  <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    grant_o <= '0;
                    busy_o  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_arbiter.sv
// tb/tb_mult_arbiter.sv - self-checking bench for mult_arbiter with an 8-cycle multiplier model

module tb_mult_arbiter;

    localparam int NREQ = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] a_bus;
    logic [31:0] b_bus;
    logic [3:0]  grant_o;
    logic [3:0]  done_o;
    logic [15:0] y_bo;
    logic        err_o;
    logic        busy_o;
    logic [7:0]  mult_a;
    logic [7:0]  mult_b;
    logic        mult_start;
    logic        m_busy;
    logic [15:0] m_y;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mult_arbiter #(.NREQ(NREQ), .TO_CYC(16)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_i        (req),
        .a_bi         (a_bus),
        .b_bi         (b_bus),
        .grant_o      (grant_o),
        .done_o       (done_o),
        .y_bo         (y_bo),
        .err_o        (err_o),
        .busy_o       (busy_o),
        .mult_a_bo    (mult_a),
        .mult_b_bo    (mult_b),
        .mult_start_o (mult_start),
        .mult_busy_i  (m_busy),
        .mult_y_bi    (m_y)
    );

    // Sequential multiplier: busy for 8 cycles after the start edge, product valid when busy drops.
    bit         m_stuck = 1'b0;
    int         m_cnt;
    logic [7:0] m_a, m_b;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
            m_y    <= 16'h0;
            m_a    <= 8'h0;
            m_b    <= 8'h0;
        end else if (m_busy) begin
            if (m_cnt == 0) begin
                m_busy <= 1'b0;
                m_y    <= m_a * m_b;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end else if (mult_start && !m_stuck) begin
            m_busy <= 1'b1;
            m_cnt  <= 7;
            m_a    <= mult_a;
            m_b    <= mult_b;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_grant(output bit ok);
        int n = 0;
        while (grant_o == 4'b0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        ok = (grant_o != 4'b0);
    endtask

    task automatic wait_done(output bit ok, output int starts);
        int n = 0;
        starts = 0;
        while (done_o == 4'b0 && n < 40) begin
            if (mult_start) starts++;
            @(negedge clk);
            n++;
        end
        ok = (done_o != 4'b0);
    endtask

    task automatic run_single(input int k, input logic [7:0] a, input logic [7:0] b,
                              input logic [15:0] y_exp);
        bit ok;
        int g, starts;
        @(negedge clk);
        req[k]         = 1'b1;
        a_bus[k*8 +: 8] = a;
        b_bus[k*8 +: 8] = b;
        wait_grant(ok);
        chk("single_grant_seen", 64'(ok), 64'd1);
        chk("single_grant", 64'(grant_o), 64'(1 << k));
        chk("single_busy", 64'(busy_o), 64'd1);
        g = cyc;
        wait_done(ok, starts);
        chk("single_done_seen", 64'(ok), 64'd1);
        chk("single_done", 64'(done_o), 64'(1 << k));
        chk("single_latency", 64'(cyc - g), 64'd10);
        chk("single_y", 64'(y_bo), 64'(y_exp));
        chk("single_starts", 64'(starts), 64'd1);
        chk("single_err", 64'(err_o), 64'd0);
        req[k] = 1'b0;
        @(negedge clk);
        chk("single_done_1cyc", 64'(done_o), 64'd0);
        chk("single_idle", 64'({grant_o, busy_o}), 64'd0);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic int rr_next(input logic [3:0] p, input int l);
        for (int i = 1; i <= NREQ; i++)
            if (p[(l + i) % NREQ]) return (l + i) % NREQ;
        return -1;
    endfunction

    typedef struct {
        int          k;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] y;
    } vec_t;

    vec_t vt[6];

    initial begin
        bit ok;
        int starts, g, prev_g;
        logic [15:0] fair_y[5];

        vt[0] = '{0, 8'd13,  8'd11,  16'd143};
        vt[1] = '{1, 8'hFF,  8'hFF,  16'hFE01};
        vt[2] = '{2, 8'h00,  8'hA5,  16'h0000};
        vt[3] = '{3, 8'd1,   8'd255, 16'd255};
        vt[4] = '{0, 8'd128, 8'd2,   16'd256};
        vt[5] = '{2, 8'd200, 8'd100, 16'd20000};
        fair_y = '{16'd2, 16'd6, 16'd12, 16'd20, 16'd2};

        rst   = 1'b1;
        req   = '0;
        a_bus = '0;
        b_bus = '0;
        #1;
        chk("reset_outputs", {grant_o, done_o, y_bo, err_o, busy_o, mult_a, mult_b, mult_start}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Table of isolated single requests.
        for (int i = 0; i < 6; i++) run_single(vt[i].k, vt[i].a, vt[i].b, vt[i].y);

        // Fairness with all requesters held high, starting from the reset pointer.
        reset_pulse();
        @(negedge clk);
        for (int k = 0; k < NREQ; k++) begin
            a_bus[k*8 +: 8] = 8'(k + 1);
            b_bus[k*8 +: 8] = 8'(k + 2);
        end
        req    = 4'hF;
        prev_g = 0;
        for (int i = 0; i < 5; i++) begin
            wait_grant(ok);
            chk("fair_grant_seen", 64'(ok), 64'd1);
            chk("fair_grant", 64'(grant_o), 64'(1 << (i % NREQ)));
            g = cyc;
            if (i > 0) chk("fair_period", 64'(g - prev_g), 64'd12);
            prev_g = g;
            wait_done(ok, starts);
            chk("fair_done", 64'(done_o), 64'(1 << (i % NREQ)));
            chk("fair_y", 64'(y_bo), 64'(fair_y[i]));
            if (i == 4) req = '0;
            @(negedge clk);
            chk("fair_done_1cyc", 64'(done_o), 64'd0);
        end

        // Asynchronous reset during WAIT_DONE drops the operation.
        @(negedge clk);
        req[1] = 1'b1;
        a_bus[15:8] = 8'd7;
        b_bus[15:8] = 8'd9;
        wait_grant(ok);
        chk("rstmid_grant", 64'(grant_o), 64'b0010);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rstmid_outputs", {grant_o, done_o, y_bo, err_o, busy_o, mult_a, mult_b, mult_start}, 64'd0);
        req = '0;
        begin
            int seen = 0;
            repeat (3) begin
                @(negedge clk);
                if (done_o != 0) seen++;
            end
            rst = 1'b0;
            repeat (12) begin
                @(negedge clk);
                if (done_o != 0) seen++;
            end
            chk("rstmid_no_done", 64'(seen), 64'd0);
        end
        run_single(2, 8'd17, 8'd3, 16'd51);

        // Withdrawn request is never served; operand changes after grant are ignored.
        @(negedge clk);
        req[0]     = 1'b1;
        a_bus[7:0] = 8'd5;
        b_bus[7:0] = 8'd6;
        wait_grant(ok);
        chk("wd_grant", 64'(grant_o), 64'b0001);
        req[2]     = 1'b1;
        a_bus[7:0] = 8'd99;
        b_bus[7:0] = 8'd77;
        @(negedge clk);
        req[2] = 1'b0;
        wait_done(ok, starts);
        chk("wd_done", 64'(done_o), 64'b0001);
        chk("wd_latched_y", 64'(y_bo), 64'd30);
        req[0] = 1'b0;
        begin
            int bad = 0;
            repeat (20) begin
                @(negedge clk);
                if (grant_o != 0) bad++;
            end
            chk("wd_never_granted", 64'(bad), 64'd0);
        end

`ifdef MULT_ARB_TIMEOUT_EN
        // Multiplier never asserts busy: watchdog releases the requester with an error.
        @(negedge clk);
        m_stuck = 1'b1;
        req[3]  = 1'b1;
        wait_grant(ok);
        g = cyc;
        wait_done(ok, starts);
        chk("to_done", 64'(done_o), 64'b1000);
        chk("to_latency", 64'(cyc - g), 64'd17);
        chk("to_err", 64'(err_o), 64'd1);
        chk("to_y", 64'(y_bo), 64'd0);
        req[3]  = 1'b0;
        m_stuck = 1'b0;
        run_single(1, 8'd12, 8'd12, 16'd144);
`endif

        // Randomized traffic against a transaction-level round-robin model.
        reset_pulse();
        begin
            int          last = NREQ - 1;
            bit          inflight = 1'b0;
            int          gidx = 0, gcyc = 0, idle_run = 0, idle_viol = 0, exp_i;
            logic [15:0] ey = 0;
            logic [3:0]  pprev = '0;
            logic [31:0] aprev = a_bus, bprev = b_bus;
            for (int t = 0; t < 2500; t++) begin
                @(negedge clk);
                if (!inflight && grant_o != 0) begin
                    exp_i = rr_next(pprev, last);
                    chk("rand_grant", 64'(grant_o), (exp_i < 0) ? 64'd0 : 64'(1 << exp_i));
                    gidx     = (exp_i < 0) ? 0 : exp_i;
                    ey       = 16'(aprev[gidx*8 +: 8]) * 16'(bprev[gidx*8 +: 8]);
                    gcyc     = cyc;
                    inflight = 1'b1;
                    last     = gidx;
                end
                if (done_o != 0) begin
                    chk("rand_done_expected", 64'(inflight), 64'd1);
                    chk("rand_done", 64'(done_o), 64'(1 << gidx));
                    chk("rand_latency", 64'(cyc - gcyc), 64'd10);
                    chk("rand_y", 64'(y_bo), 64'(ey));
                    inflight  = 1'b0;
                    req[gidx] = 1'b0;
                end
                if (!inflight && grant_o == 0 && pprev != 0) idle_run++;
                else idle_run = 0;
                if (idle_run > 2) idle_viol++;
                for (int k = 0; k < NREQ; k++) begin
                    if (!req[k] && !(inflight && k == gidx) && $urandom_range(5) == 0) begin
                        req[k]          = 1'b1;
                        a_bus[k*8 +: 8] = 8'($urandom);
                        b_bus[k*8 +: 8] = 8'($urandom);
                    end
                end
                if (inflight && $urandom_range(3) == 0) begin
                    a_bus[gidx*8 +: 8] = 8'($urandom);
                    b_bus[gidx*8 +: 8] = 8'($urandom);
                end
                pprev = req;
                aprev = a_bus;
                bprev = b_bus;
            end
            chk("rand_no_stall", 64'(idle_viol), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
